// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

   localparam int ADDR_W   = 6;              // byte address width (64-byte program space)
   localparam int MEM_LAT  = 2;              // memory read latency in clk edges
   localparam int NBYTES   = 4;              // bytes per instruction
   localparam int INSTR_W  = 8 * NBYTES;     // assembled instruction width
   localparam int RESET_PC = 0;              // first fetch address after reset (aligned)
   localparam int IDX_W    = (NBYTES  > 1) ? $clog2(NBYTES)  : 1;
   localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for fetch_en
      ST_WAIT = 2'd1,   // address on the memory, counting out its latency
      ST_CAPT = 2'd2,   // memory data valid, capture one byte
      ST_HOLD = 2'd3    // complete instruction offered to the decoder
   } fetch_state_e;

   // Force a byte address onto an instruction boundary.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
      return a & ~(ADDR_W'(NBYTES - 1));
   endfunction

endpackage

// File: rtl/fetch_byte_asm.sv
// Byte-lane register: writes one byte into lane i_idx per load, little-endian.
module fetch_byte_asm
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic               i_load,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic [7:0]         i_byte,
   output logic [INSTR_W-1:0] o_word
);

   logic [INSTR_W-1:0] r_word;

   // Lane k occupies bits [8k+7:8k]; clear discards a partially built word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
      end else if (i_clr) begin
         r_word <= '0;
      end else if (i_load) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (i_idx == IDX_W'(k)) begin
               r_word[8*k +: 8] <= i_byte;
            end
         end
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: walks the program memory one byte at a time, waits out its read
// latency, assembles a little-endian instruction and offers it to the decoder.
//
// Handshake: instr_valid/instr_ready. A transfer happens at a posedge where both
// are high and redirect_valid is low. While instr_valid is high and no transfer
// has happened, instr and instr_pc do not change. Only one instruction is ever
// buffered; the next fetch starts after the current one is taken.
module instr_fetch
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  mem_adrs,
   output logic               mem_mode,
   output logic               mem_erase,
   input  logic [7:0]         mem_out,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output fetch_state_e       dbg_state
);

   fetch_state_e        r_state;
   fetch_state_e        w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_mem_adrs;
   logic [ADDR_W-1:0]   r_instr_pc;
   logic [IDX_W-1:0]    r_byte_idx;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic                w_issue;
   logic                w_capt;
   logic                w_accept;
   logic                w_last;
   logic                w_wait_done;
   logic [ADDR_W-1:0]   w_redirect_pc;

   assign w_last        = (r_byte_idx == IDX_W'(NBYTES - 1));
   assign w_wait_done   = (r_wait_cnt == CNT_W'(MEM_LAT - 1));
   assign w_redirect_pc = align_pc(redirect_pc);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-cycle strobes; a redirect overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_capt      = 1'b0;
      w_accept    = 1'b0;
      if (redirect_valid) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (fetch_en) begin
                  w_issue     = 1'b1;
                  w_state_nxt = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_wait_done) begin
                  w_state_nxt = ST_CAPT;
               end
            end
            ST_CAPT: begin
               w_capt      = 1'b1;
               w_state_nxt = w_last ? ST_HOLD : ST_WAIT;
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // PC, memory address, byte index and latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= ADDR_W'(RESET_PC);
         r_mem_adrs <= ADDR_W'(RESET_PC);
         r_instr_pc <= '0;
         r_byte_idx <= '0;
         r_wait_cnt <= '0;
      end else if (redirect_valid) begin
         // Point the memory at the target straight away so the restart is clean.
         r_pc       <= w_redirect_pc;
         r_mem_adrs <= w_redirect_pc;
         r_byte_idx <= '0;
         r_wait_cnt <= '0;
      end else begin
         if (w_issue) begin
            r_mem_adrs <= r_pc + ADDR_W'(r_byte_idx);
            r_wait_cnt <= '0;
         end
         if (r_state == ST_WAIT) begin
            r_wait_cnt <= w_wait_done ? '0 : r_wait_cnt + 1'b1;
         end
         if (w_capt) begin
            if (w_last) begin
               // Address stays put while the instruction is held.
               r_instr_pc <= r_pc;
            end else begin
               r_byte_idx <= r_byte_idx + 1'b1;
               r_mem_adrs <= r_mem_adrs + 1'b1;
            end
         end
         if (w_accept) begin
            r_pc       <= r_pc + ADDR_W'(NBYTES);
            r_byte_idx <= '0;
         end
      end
   end

   fetch_byte_asm u_byte_asm (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (redirect_valid),
      .i_load (w_capt),
      .i_idx  (r_byte_idx),
      .i_byte (mem_out),
      .o_word (instr)
   );

   assign mem_adrs    = r_mem_adrs;
   assign mem_mode    = 1'b0;
   assign mem_erase   = 1'b0;
   assign instr_valid = (r_state == ST_HOLD);
   assign instr_pc    = r_instr_pc;
   assign dbg_state   = r_state;

endmodule
